// File: rtl/cmd_arbiter.sv
// -----------------------------------------------------------------------------
// cmd_arbiter
//
// Shares the single cmd_proc command port between the UART host path and the
// tour-replay command generator. One command is granted at a time: it is
// latched, presented to cmd_proc with cmd_rdy, and the arbiter keeps ownership
// until cmd_proc reports completion with send_resp. The completion pulse is
// routed back only to the requester that owned the command.
//
// UART has fixed priority, but after MAX_CONSEC back-to-back UART grants made
// while the tour path was also waiting, the next grant goes to tour.
//
// Optional feature macro: CMD_ARB_TIMEOUT_EN
//   defined   : a TIMEOUT_W-bit watchdog aborts a command that stays in
//               ISSUE/WAIT too long and sets the sticky timeout_err flag.
//   undefined : no watchdog, timeout_err is tied low, WAIT holds forever.
//
// Parameters
//   MAX_CONSEC    UART grants allowed in a row while tour is waiting
//   TIMEOUT_W     watchdog width (only present with CMD_ARB_TIMEOUT_EN)
//
// Ports
//   clk, rst        system clock, synchronous active-high reset
//   cmd_uart        16-bit UART command, valid while cmd_rdy_uart is high
//   cmd_rdy_uart    UART request level, held until clr_uart
//   clr_uart        1-cycle pulse: UART command accepted
//   cmd_tour        16-bit tour command, valid while cmd_rdy_tour is high
//   cmd_rdy_tour    tour request level, held until clr_tour
//   clr_tour        1-cycle pulse: tour command accepted
//   cmd             latched command to cmd_proc
//   cmd_rdy         command valid to cmd_proc
//   clr_cmd_rdy     cmd_proc has consumed cmd
//   send_resp       cmd_proc has finished executing cmd
//   resp_vld_uart   1-cycle completion pulse to the UART path
//   resp_vld_tour   1-cycle completion pulse to the tour path
//   owner           0 = UART, 1 = tour; meaningful while busy
//   busy            high while a command is outstanding (ISSUE or WAIT)
//   timeout_err     sticky watchdog flag
// -----------------------------------------------------------------------------
module cmd_arbiter #(
  parameter int MAX_CONSEC = 3
`ifdef CMD_ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT_W  = 24
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cmd_uart,
  input  logic        cmd_rdy_uart,
  output logic        clr_uart,
  input  logic [15:0] cmd_tour,
  input  logic        cmd_rdy_tour,
  output logic        clr_tour,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  output logic        resp_vld_uart,
  output logic        resp_vld_tour,
  output logic        owner,
  output logic        busy,
  output logic        timeout_err
);

  localparam int CW = (MAX_CONSEC < 1) ? 1 : $clog2(MAX_CONSEC + 1);
  localparam logic [CW-1:0] CONSEC_MAX = CW'(MAX_CONSEC);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] consec;
  logic [CW-1:0] consec_nxt;
  logic [15:0]   cmd_nxt;
  logic          cmd_rdy_nxt;
  logic          owner_nxt;
  logic          clr_uart_nxt;
  logic          clr_tour_nxt;
  logic          resp_uart_nxt;
  logic          resp_tour_nxt;
  logic          busy_nxt;
  logic          grant_tour;

`ifdef CMD_ARB_TIMEOUT_EN
  localparam logic [TIMEOUT_W-1:0] WD_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

  logic [TIMEOUT_W-1:0] wd;
  logic [TIMEOUT_W-1:0] wd_nxt;
  logic                 timeout_nxt;
`endif

  // Tour wins when UART is idle, or when UART has already taken its allowed
  // streak of grants while tour was left waiting.
  assign grant_tour = cmd_rdy_tour && (!cmd_rdy_uart || (consec == CONSEC_MAX));

  // Next-state and next-output logic. Every output is produced here as a
  // "next" value and registered below, so the pulses and cmd_rdy all appear
  // the cycle after the condition that causes them. The watchdog, when built
  // in, sits after the normal transitions so it can override a stuck command
  // but never preempts a completion in the same cycle.
  always_comb begin
    state_nxt     = state;
    consec_nxt    = consec;
    cmd_nxt       = cmd;
    cmd_rdy_nxt   = cmd_rdy;
    owner_nxt     = owner;
    clr_uart_nxt  = 1'b0;
    clr_tour_nxt  = 1'b0;
    resp_uart_nxt = 1'b0;
    resp_tour_nxt = 1'b0;

    case (state)
      IDLE: begin
        if (cmd_rdy_uart || cmd_rdy_tour) begin
          state_nxt   = ISSUE;
          cmd_rdy_nxt = 1'b1;
          owner_nxt   = grant_tour;
          if (grant_tour) begin
            cmd_nxt      = cmd_tour;
            clr_tour_nxt = 1'b1;
            consec_nxt   = '0;
          end else begin
            cmd_nxt      = cmd_uart;
            clr_uart_nxt = 1'b1;
            if (!cmd_rdy_tour) begin
              consec_nxt = '0;
            end else if (consec != CONSEC_MAX) begin
              consec_nxt = consec + 1'b1;
            end
          end
        end
      end

      ISSUE: begin
        if (clr_cmd_rdy) begin
          cmd_rdy_nxt = 1'b0;
          if (send_resp) begin
            state_nxt     = IDLE;
            resp_uart_nxt = !owner;
            resp_tour_nxt = owner;
          end else begin
            state_nxt = WAIT;
          end
        end
      end

      WAIT: begin
        if (send_resp) begin
          state_nxt     = IDLE;
          resp_uart_nxt = !owner;
          resp_tour_nxt = owner;
        end
      end

      default: begin
        state_nxt   = IDLE;
        cmd_rdy_nxt = 1'b0;
      end
    endcase

`ifdef CMD_ARB_TIMEOUT_EN
    wd_nxt      = wd;
    timeout_nxt = timeout_err;
    if (state == IDLE) begin
      wd_nxt = '0;
    end else if (state_nxt != IDLE) begin
      if (wd == WD_LAST) begin
        state_nxt   = IDLE;
        cmd_rdy_nxt = 1'b0;
        timeout_nxt = 1'b1;
      end else begin
        wd_nxt = wd + 1'b1;
      end
    end
`endif

    busy_nxt = (state_nxt != IDLE);
  end

  // State and output registers. Reset abandons any command in flight without
  // emitting a clr or resp pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      consec        <= '0;
      cmd           <= 16'h0000;
      cmd_rdy       <= 1'b0;
      owner         <= 1'b0;
      clr_uart      <= 1'b0;
      clr_tour      <= 1'b0;
      resp_vld_uart <= 1'b0;
      resp_vld_tour <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state         <= state_nxt;
      consec        <= consec_nxt;
      cmd           <= cmd_nxt;
      cmd_rdy       <= cmd_rdy_nxt;
      owner         <= owner_nxt;
      clr_uart      <= clr_uart_nxt;
      clr_tour      <= clr_tour_nxt;
      resp_vld_uart <= resp_uart_nxt;
      resp_vld_tour <= resp_tour_nxt;
      busy          <= busy_nxt;
    end
  end

`ifdef CMD_ARB_TIMEOUT_EN
  // Watchdog counter and its sticky error flag; only reset clears the flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd          <= '0;
      timeout_err <= 1'b0;
    end else begin
      wd          <= wd_nxt;
      timeout_err <= timeout_nxt;
    end
  end
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_cmd_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cmd_arbiter
//
// Self-checking bench for cmd_arbiter in its default build (watchdog absent).
// Two requester models keep queues of pending commands, a cmd_proc model
// consumes and completes commands, and a transaction-level reference model
// predicts each grant and completion. Predictions go into scoreboard queues
// that a separate monitor drains and compares against the DUT pulses.
// -----------------------------------------------------------------------------
module tb_cmd_arbiter;

  localparam int MAX_CONSEC = 3;

  logic        clk;
  logic        rst;
  logic [15:0] cmd_uart;
  logic        cmd_rdy_uart;
  logic        clr_uart;
  logic [15:0] cmd_tour;
  logic        cmd_rdy_tour;
  logic        clr_tour;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        send_resp;
  logic        resp_vld_uart;
  logic        resp_vld_tour;
  logic        owner;
  logic        busy;
  logic        timeout_err;

  cmd_arbiter #(.MAX_CONSEC(MAX_CONSEC)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_uart     (cmd_uart),
    .cmd_rdy_uart (cmd_rdy_uart),
    .clr_uart     (clr_uart),
    .cmd_tour     (cmd_tour),
    .cmd_rdy_tour (cmd_rdy_tour),
    .clr_tour     (clr_tour),
    .cmd          (cmd),
    .cmd_rdy      (cmd_rdy),
    .clr_cmd_rdy  (clr_cmd_rdy),
    .send_resp    (send_resp),
    .resp_vld_uart(resp_vld_uart),
    .resp_vld_tour(resp_vld_tour),
    .owner        (owner),
    .busy         (busy),
    .timeout_err  (timeout_err)
  );

  typedef struct {
    bit          tour;
    logic [15:0] cmd;
  } grant_t;

  int          tests_run = 0;
  int          failed    = 0;

  logic [15:0] uart_q[$];
  logic [15:0] tour_q[$];
  grant_t      exp_grant_q[$];
  bit          exp_resp_q[$];
  bit          grant_log[$];

  bit          mon_en    = 1'b0;
  bit          log_en    = 1'b0;
  bit          auto_req  = 1'b0;
  bit          auto_proc = 1'b0;

  bit          m_busy     = 1'b0;
  bit          m_consumed = 1'b0;
  bit          m_owner    = 1'b0;
  logic [15:0] m_cmd      = 16'h0000;
  int          m_streak   = 0;

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Absolute time limit so a stuck run still ends with a reported failure.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, actual running expected finished");
    $fatal(1, "[TB] time limit");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      failed++;
      $display("[TB] FAIL %s: actual %0h required %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drives every DUT input for the next rising edge. Requesters retire their
  // head command when they see their clr pulse; the cmd_proc model reacts to
  // what the arbiter currently presents, including deliberately ignored
  // strobes in IDLE, ISSUE and WAIT.
  task automatic applyStimulus();
    if (clr_uart && uart_q.size() > 0) void'(uart_q.pop_front());
    if (clr_tour && tour_q.size() > 0) void'(tour_q.pop_front());
    if (auto_req) begin
      if (uart_q.size() < 4 && $urandom_range(0, 3) == 0) uart_q.push_back(16'($urandom));
      if (tour_q.size() < 4 && $urandom_range(0, 3) == 0) tour_q.push_back(16'($urandom));
    end
    cmd_rdy_uart = (uart_q.size() != 0);
    cmd_uart     = (uart_q.size() != 0) ? uart_q[0] : 16'h0000;
    cmd_rdy_tour = (tour_q.size() != 0);
    cmd_tour     = (tour_q.size() != 0) ? tour_q[0] : 16'h0000;
    if (auto_proc) begin
      clr_cmd_rdy = 1'b0;
      send_resp   = 1'b0;
      if (cmd_rdy) begin
        if ($urandom_range(0, 2) == 0) begin
          clr_cmd_rdy = 1'b1;
          send_resp   = ($urandom_range(0, 2) == 0);
        end else begin
          send_resp = ($urandom_range(0, 7) == 0);
        end
      end else if (busy) begin
        send_resp   = ($urandom_range(0, 2) == 0);
        clr_cmd_rdy = ($urandom_range(0, 3) == 0);
      end else begin
        clr_cmd_rdy = ($urandom_range(0, 7) == 0);
        send_resp   = ($urandom_range(0, 7) == 0);
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    applyStimulus();
  endtask

  // Reference model, one step per rising edge, expressed as transactions:
  // an idle arbiter picks a winner from the pending requests, a busy one
  // waits for "consumed" then "done" from cmd_proc. Each predicted grant and
  // completion is pushed to the scoreboard.
  always @(posedge clk) begin
    grant_t g;
    if (rst) begin
      m_busy     = 1'b0;
      m_consumed = 1'b0;
      m_owner    = 1'b0;
      m_cmd      = 16'h0000;
      m_streak   = 0;
    end else if (!m_busy) begin
      if (cmd_rdy_uart || cmd_rdy_tour) begin
        g.tour = cmd_rdy_tour && (!cmd_rdy_uart || m_streak >= MAX_CONSEC);
        g.cmd  = g.tour ? cmd_tour : cmd_uart;
        if (g.tour || !cmd_rdy_tour) m_streak = 0;
        else if (m_streak < MAX_CONSEC) m_streak = m_streak + 1;
        m_busy     = 1'b1;
        m_consumed = 1'b0;
        m_owner    = g.tour;
        m_cmd      = g.cmd;
        exp_grant_q.push_back(g);
      end
    end else if (!m_consumed) begin
      if (clr_cmd_rdy) begin
        m_consumed = 1'b1;
        if (send_resp) begin
          m_busy = 1'b0;
          exp_resp_q.push_back(m_owner);
        end
      end
    end else if (send_resp) begin
      m_busy = 1'b0;
      exp_resp_q.push_back(m_owner);
    end
  end

  // Monitor: compares level outputs against the model every cycle and drains
  // the scoreboard whenever the DUT pulses (or should have pulsed).
  always @(negedge clk) begin
    grant_t   g;
    bit       r;
    bit       have;
    logic [1:0] want;
    if (mon_en) begin
      checkOutput("busy", 32'(busy), 32'(m_busy));
      checkOutput("cmd_rdy", 32'(cmd_rdy), 32'(m_busy && !m_consumed));
      checkOutput("owner", 32'(owner), 32'(m_owner));
      checkOutput("timeout_err", 32'(timeout_err), 32'd0);
      if (m_busy) checkOutput("cmd", 32'(cmd), 32'(m_cmd));

      have = (exp_grant_q.size() != 0);
      want = 2'b00;
      if (have) begin
        g    = exp_grant_q.pop_front();
        want = g.tour ? 2'b01 : 2'b10;
      end
      if (have || clr_uart || clr_tour) begin
        checkOutput("grant_pulse", 32'({clr_uart, clr_tour}), 32'(want));
        if (have) checkOutput("grant_cmd", 32'(cmd), 32'(g.cmd));
      end
      if (log_en && (clr_uart || clr_tour)) grant_log.push_back(clr_tour);

      have = (exp_resp_q.size() != 0);
      want = 2'b00;
      if (have) begin
        r    = exp_resp_q.pop_front();
        want = r ? 2'b01 : 2'b10;
      end
      if (have || resp_vld_uart || resp_vld_tour)
        checkOutput("resp_pulse", 32'({resp_vld_uart, resp_vld_tour}), 32'(want));
    end
  end

  // Directed scenarios first, then a long randomized run with occasional
  // resets, then a drain phase.
  initial begin
    bit exp_order[8] = '{0, 0, 0, 1, 0, 0, 0, 1};
    int n;

    rst          = 1'b1;
    cmd_uart     = 16'h0000;
    cmd_rdy_uart = 1'b0;
    cmd_tour     = 16'h0000;
    cmd_rdy_tour = 1'b0;
    clr_cmd_rdy  = 1'b0;
    send_resp    = 1'b0;
    repeat (3) cycle();

    checkOutput("rst_cmd", 32'(cmd), 32'h0);
    checkOutput("rst_cmd_rdy", 32'(cmd_rdy), 32'h0);
    checkOutput("rst_clr", 32'({clr_uart, clr_tour}), 32'h0);
    checkOutput("rst_resp", 32'({resp_vld_uart, resp_vld_tour}), 32'h0);
    checkOutput("rst_owner_busy", 32'({owner, busy}), 32'h0);
    checkOutput("rst_timeout", 32'(timeout_err), 32'h0);
    mon_en = 1'b1;

    // Single UART command.
    rst = 1'b0;
    uart_q.push_back(16'h2002);
    applyStimulus();
    @(negedge clk);
    checkOutput("t1_cmd", 32'(cmd), 32'h2002);
    checkOutput("t1_cmd_rdy", 32'(cmd_rdy), 32'h1);
    checkOutput("t1_clr_uart", 32'({clr_uart, clr_tour}), 32'h2);
    checkOutput("t1_owner_busy", 32'({owner, busy}), 32'h1);
    applyStimulus();
    clr_cmd_rdy = 1'b1;

    // Consume, then complete 10 cycles later.
    @(negedge clk);
    checkOutput("t2_cmd_rdy_low", 32'(cmd_rdy), 32'h0);
    checkOutput("t2_clr_once", 32'(clr_uart), 32'h0);
    checkOutput("t2_busy", 32'(busy), 32'h1);
    clr_cmd_rdy = 1'b0;
    applyStimulus();
    repeat (9) cycle();
    checkOutput("t2_still_busy", 32'(busy), 32'h1);
    send_resp = 1'b1;
    @(negedge clk);
    checkOutput("t2_resp", 32'({resp_vld_uart, resp_vld_tour}), 32'h2);
    checkOutput("t2_idle", 32'(busy), 32'h0);
    send_resp = 1'b0;
    applyStimulus();
    @(negedge clk);
    checkOutput("t2_resp_once", 32'(resp_vld_uart), 32'h0);

    // Tour command with consume and completion in the same ISSUE cycle.
    tour_q.push_back(16'h3BF1);
    applyStimulus();
    @(negedge clk);
    checkOutput("t4_cmd", 32'(cmd), 32'h3BF1);
    checkOutput("t4_owner", 32'(owner), 32'h1);
    checkOutput("t4_clr_tour", 32'({clr_uart, clr_tour}), 32'h1);
    applyStimulus();
    clr_cmd_rdy = 1'b1;
    send_resp   = 1'b1;
    @(negedge clk);
    checkOutput("t4_resp", 32'({resp_vld_uart, resp_vld_tour}), 32'h1);
    checkOutput("t4_idle", 32'({cmd_rdy, busy}), 32'h0);
    clr_cmd_rdy = 1'b0;
    send_resp   = 1'b0;
    applyStimulus();
    @(negedge clk);
    checkOutput("t4_resp_once", 32'(resp_vld_tour), 32'h0);

    // Reset while waiting for completion.
    uart_q.push_back(16'h5A5A);
    applyStimulus();
    @(negedge clk);
    applyStimulus();
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    checkOutput("t5_in_wait", 32'({cmd_rdy, busy}), 32'h1);
    clr_cmd_rdy = 1'b0;
    rst         = 1'b1;
    applyStimulus();
    @(negedge clk);
    rst = 1'b0;
    checkOutput("t5_rst_cmd", 32'(cmd), 32'h0);
    checkOutput("t5_rst_flags",
                32'({cmd_rdy, clr_uart, clr_tour, resp_vld_uart, resp_vld_tour, owner, busy}),
                32'h0);
    uart_q.push_back(16'h0F0F);
    applyStimulus();
    @(negedge clk);
    checkOutput("t5_regrant_cmd", 32'(cmd), 32'h0F0F);
    checkOutput("t5_regrant_clr", 32'({clr_uart, clr_tour}), 32'h2);
    applyStimulus();
    clr_cmd_rdy = 1'b1;
    send_resp   = 1'b1;
    @(negedge clk);
    checkOutput("t5_resp", 32'({resp_vld_uart, resp_vld_tour}), 32'h2);
    clr_cmd_rdy = 1'b0;
    send_resp   = 1'b0;

    // Both requesters saturated: starvation guard sets the grant order.
    for (int i = 0; i < 8; i++) begin
      uart_q.push_back(16'h1000 + 16'(i));
      tour_q.push_back(16'h8000 + 16'(i));
    end
    log_en    = 1'b1;
    auto_proc = 1'b1;
    applyStimulus();
    n = 0;
    while (grant_log.size() < 8 && n < 400) begin
      cycle();
      n++;
    end
    log_en = 1'b0;
    checkOutput("t3_grant_count", 32'(grant_log.size()), 32'd8);
    for (int i = 0; i < 8 && i < grant_log.size(); i++)
      checkOutput($sformatf("t3_grant_%0d", i), 32'(grant_log[i]), 32'(exp_order[i]));

    // Randomized traffic with rare resets.
    auto_req = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 299) == 0);
      applyStimulus();
    end
    rst = 1'b0;

    // Drain outstanding requests.
    auto_req = 1'b0;
    n = 0;
    while ((uart_q.size() != 0 || tour_q.size() != 0 || m_busy) && n < 1000) begin
      cycle();
      n++;
    end
    checkOutput("drain_done",
                32'(uart_q.size() + tour_q.size() + int'(m_busy)), 32'd0);
    cycle();
    cycle();

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
